// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared digit constants and FSM state type for the sequential binary-to-BCD converter
package bin2bcd_pkg;
   localparam int DIG_W = 4;
   localparam logic [DIG_W-1:0] ADD_THR = 4'd5;
   localparam logic [DIG_W-1:0] ADD_OFF = 4'd3;
   typedef enum logic {IDLE, SHIFT} state_e;
endpackage

// File: rtl/bin2bcd_seq_adj.sv
// bcd_digit_adj: combinational double-dabble step, adds 3 to a BCD digit of 5 or more
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [DIG_W-1:0] din,
   output logic [DIG_W-1:0] dout
);
   always_comb dout = (din >= ADD_THR) ? din + ADD_OFF : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary-to-BCD converter, W cycles per conversion
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int W = 8,
   parameter int D = 3
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [W-1:0]       bin,
   output logic               busy,
   output logic               done,
   output logic [DIG_W*D-1:0] bcd,
   output logic [D-1:0]       blank,
   output logic               overflow
);
   localparam int CW = $clog2(W + 1);
   localparam logic [DIG_W*D-1:0] ALL9 = {D{4'h9}};
   localparam logic [D-1:0] BLANK_RST = ~D'(1);

   if (W < 1 || D < 1) begin : g_bad_param
      $error("bin2bcd_seq: W and D must both be >= 1");
   end

   state_e             state_q, state_d;
   logic [W-1:0]       bin_q, bin_d;
   logic [DIG_W*D-1:0] sh_q, sh_d, adj;
   logic               acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [DIG_W*D-1:0] bcd_q, bcd_d;
   logic [D-1:0]       blank_q, blank_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;
   logic               z;

   for (genvar g = 0; g < D; g++) begin : g_adj
      bcd_digit_adj u_adj (.din(sh_q[DIG_W*g +: DIG_W]), .dout(adj[DIG_W*g +: DIG_W]));
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      blank_d = blank_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      z       = 1'b1;
      if (state_q == IDLE) begin
         if (start) begin
            state_d = SHIFT;
            bin_d   = bin;
            sh_d    = '0;
            acc_d   = 1'b0;
            cnt_d   = '0;
         end
      end else begin
         // a 1 leaving the top digit means the value cannot fit in D digits
         sh_d  = {adj[DIG_W*D-2:0], bin_q[W-1]};
         bin_d = bin_q << 1;
         acc_d = acc_q | adj[DIG_W*D-1];
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CW'(W - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ovf_d   = acc_d;
            bcd_d   = acc_d ? ALL9 : sh_d;
            for (int i = D - 1; i >= 1; i--) begin
               z          = z & (bcd_d[DIG_W*i +: DIG_W] == '0);
               blank_d[i] = z;
            end
            blank_d[0] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         bin_q   <= '0;
         sh_q    <= '0;
         acc_q   <= 1'b0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         blank_q <= BLANK_RST;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         blank_q <= blank_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign busy     = (state_q == SHIFT);
   assign done     = done_q;
   assign bcd      = bcd_q;
   assign blank    = blank_q;
   assign overflow = ovf_q;
endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter W, default 8, binary input width in bits (W >= 1).
REQ-002 Parameter D, default 3, number of BCD output digits (D >= 1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  conversion request; sampled only in IDLE.
REQ-006 bin  input  W  binary value to convert; sampled only on the accepted start edge.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse; result outputs were updated on the same edge.
REQ-009 bcd  output  4*D  packed BCD result; digit 0 (units) is in bcd[3:0].
REQ-010 blank  output  D  per-digit leading-zero mask; bit i high means digit i is a leading zero.
REQ-011 overflow  output  1  high when the last converted value was >= 10^D.

Function
REQ-012 The block SHALL use a two-state FSM:
- IDLE: start=1 moves the FSM to SHIFT, loads bin into the binary shift field, clears the BCD field and overflow accumulator, and clears the iteration counter.
- SHIFT: each cycle, every digit >= 5 gets +3 added, then the combined {BCD, binary} register shifts left by 1.
REQ-013 SHIFT SHALL perform exactly W iterations, then return to IDLE on the edge of the W-th iteration.
REQ-014 Latency from the accepted start edge k to result SHALL be exactly W cycles:
- bcd, blank, overflow and done are registered on edge k+W.
- done is high for the one cycle after edge k+W.
REQ-015 busy SHALL be high from edge k to edge k+W and low in IDLE; busy and done are never high together.
REQ-016 A start asserted while busy=1 SHALL be ignored; it is not queued.
REQ-017 A start asserted in the done cycle SHALL be accepted, giving back-to-back conversions every W+1 cycles at most.
REQ-018 Changes on bin after the accepted start edge SHALL NOT affect the running conversion.
REQ-019 Overflow detection: any 1 shifted out of the top digit during SHIFT SHALL set a sticky overflow accumulator.
REQ-020 On an overflow result, bcd SHALL saturate to all digits = 9, with overflow=1 and blank=0.
REQ-021 On a non-overflow result, bcd SHALL equal the exact decimal value of bin, with overflow=0.
REQ-022 Blank rule:
- blank[i]=1 for i >= 1 exactly when digits i..D-1 are all zero.
- blank[0] is always 0.
REQ-023 Outputs bcd, blank and overflow SHALL hold their values between done pulses.
REQ-024 The iteration counter SHALL be $clog2(W+1) bits wide and SHALL NOT wrap during a conversion.

Reset
REQ-025 rst_n=0 SHALL immediately force the following, regardless of FSM state:
- FSM to IDLE, busy=0, done=0, overflow=0.
- bcd=0, blank={D-1 ones, 0}.
- Internal shift register and counter to 0.
REQ-026 Reset during SHIFT SHALL abort the conversion; no done pulse SHALL follow for the aborted request.
REQ-027 The first start after rst_n deasserts SHALL be accepted normally.

Structure
REQ-028 A shared package bin2bcd_pkg SHALL hold:
- digit width constant (4), add-3 threshold (5) and offset (3);
- the FSM state typedef.
REQ-029 One sub-module, bcd_digit_adj, SHALL implement the combinational per-digit add-3 step; bin2bcd_seq instantiates it D times.
REQ-030 Parameter legality (W >= 1, D >= 1) SHALL be checked at elaboration.

Verification
REQ-031 W=8, D=3, bin=255, start for 1 cycle -> done 8 cycles later, bcd=0x255, blank=000, overflow=0.
REQ-032 W=8, D=3:
- bin=7 -> bcd=0x007, blank=110.
- bin=0 -> bcd=0x000, blank=110.
REQ-033 W=8, D=2, bin=100 -> bcd=0x99, overflow=1, blank=00; then bin=99 -> bcd=0x99, overflow=0.
REQ-034 W=8, D=3:
- start held high continuously -> conversions complete every 9 cycles;
- extra starts during busy produce no extra done;
- bin changed mid-conversion does not alter the result.
REQ-035 W=8, D=3, rst_n pulsed low 3 cycles after start -> no done pulse, outputs at reset values; a next start with bin=42 -> bcd=0x042.
REQ-036 W=16, D=5, bin=65535 -> done after 16 cycles, bcd=0x65535, overflow=0.
